mem_access_ctrl: RTL and testbench



---
 rtl/mem_access_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store front end for a 1024x32 single-port data RAM.
// Takes byte, half and word requests on a byte-addressed CPU port and checks
// their alignment. It drives the RAM's word-addressed port, doing sub-word
// stores as a read-modify-write. Loads are returned zero- or sign-extended.
//
// Handshake: a request is accepted on a rising edge where req_valid=1 and
// req_ready=1. req_ready is high only in IDLE. The response is a single-cycle
// rsp_valid pulse, which is never back-pressured. rsp_err and rsp_rdata are
// meaningful only while rsp_valid is high.
//
// Optional feature: define MEM_ACCESS_CNT_EN to add the saturating acc_cnt
// and err_cnt response counters.
module mem_access_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              ram_we,
    output logic [ADDR_W-3:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic [2:0]        dbg_state
`ifdef MEM_ACCESS_CNT_EN
    ,
    output logic [15:0]       acc_cnt,
    output logic [15:0]       err_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t            state;
    logic              l_we;
    logic [1:0]        l_size;
    logic              l_signed;
    logic [ADDR_W-1:0] l_addr;
    logic [31:0]       l_wdata;
    logic [31:0]       wr_word;
    logic              misalign;

    // Extract the addressed lane from a RAM word and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] d,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off,
                                                input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (size)
            2'b00:   r = {{24{sgn & b[7]}}, b};
            2'b01:   r = {{16{sgn & h[15]}}, h};
            default: r = d;
        endcase
        return r;
    endfunction

    // Overwrite only the addressed lane(s) of the old word with store data.
    function automatic logic [31:0] store_merge(input logic [31:0] d,
                                                input logic [31:0] w,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = d;
        case (size)
            2'b00: begin
                case (off)
                    2'd0:    r[7:0]   = w[7:0];
                    2'd1:    r[15:8]  = w[7:0];
                    2'd2:    r[23:16] = w[7:0];
                    default: r[31:24] = w[7:0];
                endcase
            end
            2'b01: begin
                if (off[1]) r[31:16] = w[15:0];
                else        r[15:0]  = w[15:0];
            end
            default: r = w;
        endcase
        return r;
    endfunction

    // Flag illegal size or an address that is not aligned to the access size.
    always_comb begin
        misalign = 1'b0;
        case (req_size)
            2'b01:   misalign = req_addr[0];
            2'b10:   misalign = |req_addr[1:0];
            2'b11:   misalign = 1'b1;
            default: misalign = 1'b0;
        endcase
    end

    // RAM port and handshake are decoded from the state register. This lets
    // ram_we drop the moment reset is asserted.
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        ram_we    = (state == WRITE);
        ram_addr  = l_addr[ADDR_W-1:2];
        ram_din   = (state == WRITE) ? wr_word : 32'd0;
        dbg_state = state;
    end

    // Main sequencer: accept, optional read, merge/extend, optional write, respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            l_we      <= 1'b0;
            l_size    <= 2'b00;
            l_signed  <= 1'b0;
            l_addr    <= '0;
            l_wdata   <= 32'd0;
            wr_word   <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        l_we     <= req_we;
                        l_size   <= req_size;
                        l_signed <= req_signed;
                        l_addr   <= req_addr;
                        l_wdata  <= req_wdata;
                        if (misalign) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= 32'd0;
                            state     <= RESP;
                        end else if (req_we && req_size == 2'b10) begin
                            wr_word <= req_wdata;
                            state   <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: state <= CAPTURE;
                CAPTURE: begin
                    if (l_we) begin
                        wr_word <= store_merge(ram_dout, l_wdata, l_size, l_addr[1:0]);
                        state   <= WRITE;
                    end else begin
                        rsp_rdata <= load_extend(ram_dout, l_size, l_addr[1:0], l_signed);
                        rsp_err   <= 1'b0;
                        state     <= RESP;
                    end
                end
                WRITE: begin
                    rsp_rdata <= 32'd0;
                    rsp_err   <= 1'b0;
                    state     <= RESP;
                end
                RESP: begin
                    rsp_rdata <= 32'd0;
                    rsp_err   <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ACCESS_CNT_EN
    // Saturating counters of good and failed responses, one count per RESP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= 16'd0;
            err_cnt <= 16'd0;
        end else if (state == RESP) begin
            if (rsp_err) begin
                if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end else begin
                if (acc_cnt != 16'hFFFF) acc_cnt <= acc_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 1024x32 RAM model.
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [2:0]  dbg_state;
`ifdef MEM_ACCESS_CNT_EN
  logic [15:0] acc_cnt;
  logic [15:0] err_cnt;
`endif

  int n_chk;
  int n_fail;

  logic [31:0] mem [1024];

  int          lat;
  int          we_cnt;
  int          we_at;
  logic [9:0]  we_addr;
  logic [31:0] we_din;
  logic [31:0] rdata;
  logic        err;

  mem_access_ctrl #(.ADDR_W(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout),
    .dbg_state  (dbg_state)
`ifdef MEM_ACCESS_CNT_EN
    ,
    .acc_cnt    (acc_cnt),
    .err_cnt    (err_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: synchronous write, registered read
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and follow it until the response pulse (bounded).
  task automatic run_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [11:0] addr, input logic [31:0] wdata);
    int n;
    @(negedge clk);
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n      = 1;
    lat    = -1;
    we_cnt = 0;
    we_at  = -1;
    we_addr = '0;
    we_din  = '0;
    rdata  = '0;
    err    = 1'b0;
    while (n <= 10) begin
      if (ram_we) begin
        we_cnt++;
        we_at   = n;
        we_addr = ram_addr;
        we_din  = ram_din;
      end
      if (rsp_valid) begin
        lat   = n;
        rdata = rsp_rdata;
        err   = rsp_err;
        break;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (lat < 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL rsp_timeout observed=none expected=rsp_valid");
    end else begin
      @(posedge clk);
      #1;
      chk("rsp_pulse_one_cycle", {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'b00;
    req_signed = 1'b0;
    req_addr  = '0;
    req_wdata = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    chk("rst_rsp_rdata", rsp_rdata,          32'd0);
    chk("rst_ram_we",    {31'd0, ram_we},    32'd0);
    chk("rst_ram_addr",  {22'd0, ram_addr},  32'd0);
    chk("rst_ram_din",   ram_din,            32'd0);
`ifdef MEM_ACCESS_CNT_EN
    chk("rst_acc_cnt", {16'd0, acc_cnt}, 32'd0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
`endif
    rst_n = 1'b1;

    // signed byte load, lane 2
    mem[5] = 32'h11223344;
    run_req(1'b0, 2'b00, 1'b1, 12'h016, 32'd0);
    chk("lb_lat",   lat,   32'd3);
    chk("lb_rdata", rdata, 32'h00000022);
    chk("lb_err",   {31'd0, err}, 32'd0);
    chk("lb_no_we", we_cnt, 32'd0);

    // half loads, upper lane, signed and unsigned
    mem[5] = 32'h8899AABB;
    run_req(1'b0, 2'b01, 1'b1, 12'h016, 32'd0);
    chk("lh_s_rdata", rdata, 32'hFFFF8899);
    run_req(1'b0, 2'b01, 1'b0, 12'h016, 32'd0);
    chk("lh_u_rdata", rdata, 32'h00008899);
    // byte loads on lanes 1 and 3
    run_req(1'b0, 2'b00, 1'b1, 12'h015, 32'd0);
    chk("lb_s_lane1", rdata, 32'hFFFFFFAA);
    run_req(1'b0, 2'b00, 1'b0, 12'h017, 32'd0);
    chk("lb_u_lane3", rdata, 32'h00000088);

    // byte store via read-modify-write
    mem[2] = 32'hDEADBEEF;
    run_req(1'b1, 2'b00, 1'b0, 12'h009, 32'hFFFFFFA5);
    chk("sb_lat",     lat,    32'd4);
    chk("sb_we_cnt",  we_cnt, 32'd1);
    chk("sb_we_at",   we_at,  32'd3);
    chk("sb_we_addr", {22'd0, we_addr}, 32'd2);
    chk("sb_mem",     mem[2], 32'hDEADA5EF);
    chk("sb_rdata",   rdata,  32'd0);
    chk("sb_err",     {31'd0, err}, 32'd0);

    // half store, upper half of the same word
    run_req(1'b1, 2'b01, 1'b0, 12'h00A, 32'hABCD1234);
    chk("sh_mem", mem[2], 32'h1234A5EF);
    chk("sh_lat", lat,    32'd4);

    // word store at the top address, then read it back
    run_req(1'b1, 2'b10, 1'b0, 12'hFFC, 32'hCAFEF00D);
    chk("sw_lat",     lat,    32'd2);
    chk("sw_we_cnt",  we_cnt, 32'd1);
    chk("sw_we_at",   we_at,  32'd1);
    chk("sw_we_addr", {22'd0, we_addr}, 32'd1023);
    chk("sw_we_din",  we_din, 32'hCAFEF00D);
    run_req(1'b0, 2'b10, 1'b0, 12'hFFC, 32'd0);
    chk("lw_lat",   lat,   32'd3);
    chk("lw_rdata", rdata, 32'hCAFEF00D);

    // error cases: misaligned half, misaligned word, illegal size
    run_req(1'b0, 2'b01, 1'b0, 12'h003, 32'd0);
    chk("err_h_lat",   lat,   32'd1);
    chk("err_h_err",   {31'd0, err}, 32'd1);
    chk("err_h_rdata", rdata, 32'd0);
    run_req(1'b1, 2'b10, 1'b0, 12'h006, 32'h12345678);
    chk("err_w_lat",   lat,    32'd1);
    chk("err_w_err",   {31'd0, err}, 32'd1);
    chk("err_w_no_we", we_cnt, 32'd0);
    run_req(1'b1, 2'b11, 1'b0, 12'h000, 32'h12345678);
    chk("err_sz_err",   {31'd0, err}, 32'd1);
    chk("err_sz_rdata", rdata,  32'd0);
    chk("err_sz_no_we", we_cnt, 32'd0);
`ifdef MEM_ACCESS_CNT_EN
    chk("cnt_err", {16'd0, err_cnt}, 32'd3);
    chk("cnt_acc", {16'd0, acc_cnt}, 32'd9);
`endif

    // reset asserted during the WRITE cycle of a byte store
    mem[7] = 32'h01020304;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_size  = 2'b00;
    req_signed = 1'b0;
    req_addr  = 12'h01C;
    req_wdata = 32'h000000FF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("rstw_we_before", {31'd0, ram_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstw_we_drop", {31'd0, ram_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rstw_mem",   mem[7], 32'h01020304);
    chk("rstw_ready", {31'd0, req_ready}, 32'd1);
    chk("rstw_valid", {31'd0, rsp_valid}, 32'd0);
    run_req(1'b0, 2'b10, 1'b0, 12'h01C, 32'd0);
    chk("rstw_reload", rdata, 32'h01020304);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
